background_redraw_engine: RTL and testbench

//  Writer side of the background pixel lookup. On a start pulse it latches the game state,

---
 rtl/background_redraw_engine_pkg.sv | 32 +++
 rtl/background_redraw_engine_raster_counter.sv | 54 +++++
 rtl/background_redraw_engine.sv | 130 +++++++++++++
 tb/tb_background_redraw_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/background_redraw_engine_pkg.sv
// Shared constants for the background redraw path: screen geometry, colour width,
// game-state encodings, FSM state type and the latency-pipeline entry type.
package background_redraw_engine_pkg;

   localparam int unsigned H_RES   = 320;
   localparam int unsigned V_RES   = 240;
   localparam int unsigned COLOR_W = 3;
   localparam int unsigned X_W     = 9;
   localparam int unsigned Y_W     = 8;
   localparam int unsigned GS_W    = 4;

   localparam logic [GS_W-1:0] INITIAL         = 4'd0;
   localparam logic [GS_W-1:0] UPDATE_BRIDGE_1 = 4'd1;
   localparam logic [GS_W-1:0] UPDATE_BRIDGE_2 = 4'd2;
   localparam logic [GS_W-1:0] UPDATE_BRIDGE_3 = 4'd3;
   localparam logic [GS_W-1:0] UPDATE_BRIDGE_4 = 4'd4;
   localparam logic [GS_W-1:0] UPDATE_BRIDGE_5 = 4'd5;
   localparam logic [GS_W-1:0] UPDATE_BRIDGE_6 = 4'd6;
   localparam logic [GS_W-1:0] UPDATE_PILLAR   = 4'd7;
   localparam logic [GS_W-1:0] PLAYER_WON      = 4'd8;
   localparam logic [GS_W-1:0] FINISHED_GAME   = 4'd9;
   localparam logic [GS_W-1:0] DRAW_INITIAL    = 4'd10;

   typedef enum logic [1:0] {StIdle, StSweep, StDrain, StFinish} state_e;

   typedef struct packed {
      logic           valid;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } pix_t;

endpackage

// File: rtl/background_redraw_engine_raster_counter.sv
// Raster-order x/y coordinate counter: x fastest, synchronous clear, and a flag that is
// high while the counter sits on the final coordinate.
module background_redraw_engine_raster_counter
   import background_redraw_engine_pkg::*;
#(
   parameter int unsigned NumCols = 320,
   parameter int unsigned NumRows = 240
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           clr_i,
   input  logic           en_i,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
   output logic           last_o
);

   localparam logic [X_W-1:0] XMax = X_W'(NumCols - 1);
   localparam logic [Y_W-1:0] YMax = Y_W'(NumRows - 1);

   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr_i) begin
         x_d = '0;
         y_d = '0;
      end else if (en_i) begin
         if (x_q == XMax) begin
            x_d = '0;
            y_d = (y_q == YMax) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == XMax) && (y_q == YMax);

endmodule

// File: rtl/background_redraw_engine.sv
// Full-screen background redraw: sweeps every coordinate into the pixel lookup and plots each
// returned colour to the VGA adapter once the lookup latency has elapsed.
module background_redraw_engine
   import background_redraw_engine_pkg::X_W, background_redraw_engine_pkg::Y_W,
          background_redraw_engine_pkg::GS_W, background_redraw_engine_pkg::pix_t,
          background_redraw_engine_pkg::state_e, background_redraw_engine_pkg::StIdle,
          background_redraw_engine_pkg::StSweep, background_redraw_engine_pkg::StDrain,
          background_redraw_engine_pkg::StFinish;
#(
   parameter int unsigned H_RES       = background_redraw_engine_pkg::H_RES,
   parameter int unsigned V_RES       = background_redraw_engine_pkg::V_RES,
   parameter int unsigned ROM_LATENCY = 1,
   parameter int unsigned COLOR_W     = background_redraw_engine_pkg::COLOR_W
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start,
   input  logic [GS_W-1:0]    gameStateIn,
   output logic               busy,
   output logic               done,
   output logic [GS_W-1:0]    bgGameState,
   output logic [X_W-1:0]     bgX,
   output logic [Y_W-1:0]     bgY,
   input  logic [COLOR_W-1:0] bgColor,
   output logic [X_W-1:0]     vgaX,
   output logic [Y_W-1:0]     vgaY,
   output logic [COLOR_W-1:0] vgaColour,
   output logic               vgaPlot
);

   state_e                 state_q, state_d;
   pix_t [ROM_LATENCY-1:0] pipe_q, pipe_d;
   pix_t                   tail;
   logic [GS_W-1:0]        bg_game_state_q, bg_game_state_d;
   logic [X_W-1:0]         vga_x_q, vga_x_d;
   logic [Y_W-1:0]         vga_y_q, vga_y_d;
   logic [COLOR_W-1:0]     vga_colour_q, vga_colour_d;
   logic                   vga_plot_q, vga_plot_d;
   logic                   cnt_clr, cnt_en, cnt_last, issue, pipe_busy;
   logic [X_W-1:0]         cnt_x;
   logic [Y_W-1:0]         cnt_y;

   background_redraw_engine_raster_counter #(
      .NumCols (H_RES),
      .NumRows (V_RES)
   ) u_raster_counter (
      .clk_i  (clock),
      .rst_ni (resetn),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .x_o    (cnt_x),
      .y_o    (cnt_y),
      .last_o (cnt_last)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (start)      state_d = StSweep;
         StSweep:  if (cnt_last)   state_d = StDrain;
         StDrain:  if (!pipe_busy) state_d = StFinish;
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      busy    = (state_q == StSweep) || (state_q == StDrain);
      done    = (state_q == StFinish);
      issue   = (state_q == StSweep);
      cnt_clr = (state_q == StIdle) && start;
      // Freeze on the final coordinate so bgX/bgY hold through the drain.
      cnt_en  = (state_q == StSweep) && !cnt_last;
   end

   always_comb begin
      bg_game_state_d = bg_game_state_q;
      if (cnt_clr) bg_game_state_d = gameStateIn;

      pipe_d    = '0;
      pipe_d[0] = '{valid: issue, x: cnt_x, y: cnt_y};
      for (int i = 1; i < int'(ROM_LATENCY); i++) pipe_d[i] = pipe_q[i-1];

      pipe_busy = 1'b0;
      for (int i = 0; i < int'(ROM_LATENCY); i++) pipe_busy = pipe_busy | pipe_q[i].valid;

      tail         = pipe_q[ROM_LATENCY-1];
      vga_plot_d   = tail.valid;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      if (tail.valid) begin
         vga_x_d      = tail.x;
         vga_y_d      = tail.y;
         vga_colour_d = bgColor;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pipe_q          <= '0;
         bg_game_state_q <= '0;
         vga_x_q         <= '0;
         vga_y_q         <= '0;
         vga_colour_q    <= '0;
         vga_plot_q      <= 1'b0;
      end else begin
         pipe_q          <= pipe_d;
         bg_game_state_q <= bg_game_state_d;
         vga_x_q         <= vga_x_d;
         vga_y_q         <= vga_y_d;
         vga_colour_q    <= vga_colour_d;
         vga_plot_q      <= vga_plot_d;
      end
   end

   assign bgGameState = bg_game_state_q;
   assign bgX         = cnt_x;
   assign bgY         = cnt_y;
   assign vgaX        = vga_x_q;
   assign vgaY        = vga_y_q;
   assign vgaColour   = vga_colour_q;
   assign vgaPlot     = vga_plot_q;

endmodule

// File: tb/tb_background_redraw_engine.sv
// Bench for background_redraw_engine: a full-size instance with a 1-cycle lookup and a small
// instance with a 2-cycle lookup, each paired with a colour = (X+Y+state)%8 lookup model.
module tb_background_redraw_engine;

   localparam int HA = 320;
   localparam int VA = 240;
   localparam int LA = 1;
   localparam int HB = 12;
   localparam int VB = 5;
   localparam int LB = 2;

   logic       clk;
   logic       rst_n   [2];
   logic       start_s [2];
   logic [3:0] gs_in   [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic [3:0] bg_gs   [2];
   logic [8:0] bg_x    [2];
   logic [7:0] bg_y    [2];
   logic [8:0] vga_x   [2];
   logic [7:0] vga_y   [2];
   logic [2:0] vga_col [2];
   logic       plot_s  [2];
   logic [2:0] col_a, col_b1, col_b2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] gs;
      int         chg_cyc;
      logic [3:0] chg_gs;
      int         spur_cyc;
      int         exp_first;
      int         exp_done;
   } vec_t;

   vec_t vecs [6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   background_redraw_engine u_dut_a (
      .clock       (clk),
      .resetn      (rst_n[0]),
      .start       (start_s[0]),
      .gameStateIn (gs_in[0]),
      .busy        (busy_s[0]),
      .done        (done_s[0]),
      .bgGameState (bg_gs[0]),
      .bgX         (bg_x[0]),
      .bgY         (bg_y[0]),
      .bgColor     (col_a),
      .vgaX        (vga_x[0]),
      .vgaY        (vga_y[0]),
      .vgaColour   (vga_col[0]),
      .vgaPlot     (plot_s[0])
   );

   background_redraw_engine #(
      .H_RES       (HB),
      .V_RES       (VB),
      .ROM_LATENCY (LB)
   ) u_dut_b (
      .clock       (clk),
      .resetn      (rst_n[1]),
      .start       (start_s[1]),
      .gameStateIn (gs_in[1]),
      .busy        (busy_s[1]),
      .done        (done_s[1]),
      .bgGameState (bg_gs[1]),
      .bgX         (bg_x[1]),
      .bgY         (bg_y[1]),
      .bgColor     (col_b2),
      .vgaX        (vga_x[1]),
      .vgaY        (vga_y[1]),
      .vgaColour   (vga_col[1]),
      .vgaPlot     (plot_s[1])
   );

   function automatic logic [2:0] colour_of(input int x, input int y, input int gs);
      return 3'((x + y + gs) % 8);
   endfunction

   // Lookup models: one and two cycles of read latency.
   always @(posedge clk) begin
      col_a  <= colour_of(int'(bg_x[0]), int'(bg_y[0]), int'(bg_gs[0]));
      col_b1 <= colour_of(int'(bg_x[1]), int'(bg_y[1]), int'(bg_gs[1]));
      col_b2 <= col_b1;
   end

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_zero(input int k, input string nm);
      check({nm, " busy"}, longint'(busy_s[k]), 0);
      check({nm, " done"}, longint'(done_s[k]), 0);
      check({nm, " vgaPlot"}, longint'(plot_s[k]), 0);
      check({nm, " bgX"}, longint'(bg_x[k]), 0);
      check({nm, " bgY"}, longint'(bg_y[k]), 0);
      check({nm, " bgGameState"}, longint'(bg_gs[k]), 0);
      check({nm, " vgaX"}, longint'(vga_x[k]), 0);
      check({nm, " vgaY"}, longint'(vga_y[k]), 0);
      check({nm, " vgaColour"}, longint'(vga_col[k]), 0);
   endtask

   // One redraw on instance k; the plot stream is compared against raster order n -> (n%h, n/h).
   task automatic run(input int k, input string nm, input logic [3:0] gs, input int chg_cyc,
                      input logic [3:0] chg_gs, input int spur_cyc, input int exp_first,
                      input int exp_done);
      int h, v, n, first, done_cyc, dones, pix_bad, gs_bad, busy_bad, ex, ey;
      int wrap_x, wrap_y, last_x, last_y;
      bit fin;
      h = (k == 0) ? HA : HB;
      v = (k == 0) ? VA : VB;
      n = 0; first = -1; done_cyc = -1; dones = 0;
      pix_bad = 0; gs_bad = 0; busy_bad = 0;
      wrap_x = -1; wrap_y = -1; last_x = -1; last_y = -1;
      fin = 1'b0;
      @(negedge clk);
      start_s[k] = 1'b1;
      gs_in[k]   = gs;
      for (int c = 0; c < exp_done + 50 && !fin; c++) begin
         @(negedge clk);
         if (bg_gs[k] != gs) gs_bad++;
         if (busy_s[k] != (c < exp_done)) busy_bad++;
         if (plot_s[k]) begin
            if (first < 0) first = c;
            ex = n % h;
            ey = n / h;
            if (n == h) begin wrap_x = int'(vga_x[k]); wrap_y = int'(vga_y[k]); end
            if (n == h * v - 1) begin last_x = int'(vga_x[k]); last_y = int'(vga_y[k]); end
            if (int'(vga_x[k]) != ex || int'(vga_y[k]) != ey ||
                vga_col[k] != colour_of(ex, ey, int'(gs))) pix_bad++;
            n++;
         end
         if (done_s[k]) begin
            dones++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) fin = 1'b1;
         start_s[k] = (c == spur_cyc);
         if (c == chg_cyc) gs_in[k] = chg_gs;
      end
      start_s[k] = 1'b0;
      check({nm, " plot count"}, n, h * v);
      check({nm, " first plot cycle"}, first, exp_first);
      check({nm, " done cycle"}, done_cyc, exp_done);
      check({nm, " done pulses"}, dones, 1);
      check({nm, " bad pixels"}, pix_bad, 0);
      check({nm, " bgGameState changes"}, gs_bad, 0);
      check({nm, " busy errors"}, busy_bad, 0);
      check({nm, " wrap x"}, wrap_x, 0);
      check({nm, " wrap y"}, wrap_y, 1);
      check({nm, " last x"}, last_x, h - 1);
      check({nm, " last y"}, last_y, v - 1);
      check({nm, " busy after"}, longint'(busy_s[k]), 0);
   endtask

   initial begin
      int found, bad;
      vec_t tv;
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0; start_s[k] = 1'b0; gs_in[k] = 4'd0;
      end
      vecs[0] = '{4'd10, -1, 4'd0, -1, LB + 1, HB * VB + LB + 1};
      vecs[1] = '{4'd3, 10, 4'd8, -1, 3, 63};
      vecs[2] = '{4'd0, -1, 4'd0, 5, 3, 63};
      vecs[3] = '{4'd9, 0, 4'd1, 62, 3, 63};
      vecs[4] = '{4'd15, -1, 4'd0, 63, 3, 63};
      vecs[5] = '{4'd7, 40, 4'd2, 30, 3, 63};

      #12;
      check_zero(0, "reset A");
      check_zero(1, "reset B");
      @(negedge clk);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      repeat (2) @(negedge clk);
      check("idle busy A", longint'(busy_s[0]), 0);
      check("idle plot B", longint'(plot_s[1]), 0);

      // Full-size redraw: state change at cycle 1000 and a stray start at 5000 are ignored.
      run(0, "full", 4'd10, 1000, 4'd8, 5000, LA + 1, HA * VA + LA + 1);

      for (int i = 0; i < 6; i++) begin
         tv = vecs[i];
         run(1, $sformatf("vec%0d", i), tv.gs, tv.chg_cyc, tv.chg_gs, tv.spur_cyc,
             tv.exp_first, tv.exp_done);
      end

      for (int r = 0; r < 5; r++)
         run(1, $sformatf("rand%0d", r), 4'($urandom_range(0, 15)), $urandom_range(0, 62),
             4'($urandom_range(0, 15)), $urandom_range(1, 70), LB + 1, HB * VB + LB + 1);

      // Abort mid-sweep at pixel (7,2), then redraw from scratch.
      @(negedge clk);
      start_s[1] = 1'b1; gs_in[1] = 4'd5;
      @(negedge clk);
      start_s[1] = 1'b0;
      found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         @(negedge clk);
         if (plot_s[1] && vga_x[1] == 9'd7 && vga_y[1] == 8'd2) found = 1;
      end
      check("abort pixel reached", found, 1);
      #1 rst_n[1] = 1'b0;
      #1 check_zero(1, "abort");
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (plot_s[1] || busy_s[1]) bad++;
      end
      rst_n[1] = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (plot_s[1] || busy_s[1] || done_s[1]) bad++;
      end
      check("abort quiet cycles", bad, 0);
      run(1, "after abort", 4'd6, -1, 4'd0, -1, LB + 1, HB * VB + LB + 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
